out_stream_signature: RTL and testbench
=======================================

Name: out_stream_signature

Overview:
- Consumer end of the stimulus/response stream around the fuzzed `top`: the stimulus side drives `in_flat` once per cycle, and this block sinks the matching 330-bit `out_flat` words.
- It compacts each word into a 32-bit MISR signature so simulators can be compared by one number instead of per-cycle dumps.
- It sits beside the DUT in the bench harness and is synthesizable.
- A collection run is armed by `start`, accepts a programmed number of words, then presents signature and word count on a valid/ready handshake.

Parameters:
- DATA_W, 330, width of each sampled output word.
- SIG_W, 32, signature and chunk width.
- POLY, 32'h04C11DB7, Galois MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, signature value loaded on start.
- NCHUNK, ceil(DATA_W/SIG_W) = 11, derived localparam; not overridable.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; arms a run, honoured only in IDLE.
- cycles_target  input  32  words to collect; latched on accepted start.
- in_valid  input  1  in_data holds a word to sample.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  DUT output word (out_flat).
- sig_valid  output  1  sig_out/word_count final; held until sig_ready.
- sig_ready  input  1  consumer takes result.
- sig_out  output  SIG_W  signature register.
- word_count  output  32  words accepted in current/last run.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready, sig_valid and busy = 0.
  - sig_out=0, word_count=0, target register=0, capture register=0, chunk index=0.
- States: IDLE, COLLECT, FOLD, DONE.
- IDLE:
  - start=1: load sig=SEED, word_count=0, latch target.
  - If target==0, go to DONE; otherwise go to COLLECT.
  - start in any other state is ignored with no side effect.
- COLLECT:
  - in_ready=1 combinationally in this state only.
  - A word is accepted on in_valid&&in_ready: capture in_data, word_count+1, chunk index=0, go to FOLD.
  - in_valid low means stay in COLLECT with no change.
- FOLD: one chunk per cycle, NCHUNK cycles.
  - chunk k = capture[32k+31:32k]; chunk 10 = {22'b0, capture[329:320]}.
  - Update: sig = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ chunk.
  - After chunk NCHUNK-1: go to DONE if word_count==target, else COLLECT.
  - in_ready=0 throughout FOLD.
- Throughput and latency:
  - Max one word per NCHUNK+1 = 12 cycles.
  - sig_valid rises on the clock edge after the last fold cycle of the final word.
- DONE:
  - sig_valid=1; sig_out and word_count stable.
  - On sig_valid&&sig_ready, go to IDLE with sig_valid=0 the next cycle.
  - sig_out and word_count keep their values in IDLE until the next start.
- Outputs and arithmetic:
  - sig_out always reflects the live register, so it is mid-fold during FOLD.
  - word_count never exceeds target; no wrap handling is required.
- Reset mid-run: abandon everything immediately; no partial result is emitted.

Test Plan:
- Reset with in_valid=1 and start=1 held low-rst -> in_ready=0, sig_valid=0, busy=0, sig_out=0, word_count=0 until release plus first edge.
- start with cycles_target=0 (SEED default) -> DONE next cycle, sig_valid=1, sig_out=32'hFFFFFFFF, word_count=0, in_ready never high; sig_ready=1 -> IDLE.
- SEED=0, target=1, in_data=330'h1 -> sig_out=32'h00000400 (bit0 shifted through 10 later chunks), word_count=1; in_data=1<<320 instead -> sig_out=32'h00000001.
- SEED=0, target=3, in_data=0 with in_valid always 1 -> accepts exactly at 12-cycle spacing, in_ready low 11 cycles after each accept, sig_out=0, word_count=3.
- sig_ready held 0 for 5 cycles in DONE -> sig_valid and sig_out stable; start pulse there ignored, no reload.
- rst_n asserted during FOLD of word 2 of 4 -> outputs clear asynchronously; fresh start then completes normally with word_count=4 and the signature matching a golden-model run.

Source files
------------

// File: rtl/out_stream_signature.sv
// Output-stream signature sink: folds each accepted DATA_W-bit word into a
// SIG_W-bit Galois MISR, one SIG_W-bit chunk per cycle, then presents the
// signature and word count on a valid/ready handshake.
module out_stream_signature #(
  parameter int unsigned       DATA_W = 330,
  parameter int unsigned       SIG_W  = 32,
  parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       cycles_target,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [SIG_W-1:0]  sig_out,
  output logic [31:0]       word_count,
  output logic              busy
);

  localparam int unsigned NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StFold, StDone} state_e;

  state_e              state_q, state_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic [31:0]         count_q, count_d;
  logic [31:0]         target_q, target_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic [NCHUNK*SIG_W-1:0] cap_pad;
  logic [SIG_W-1:0]        chunk;

  // Zero-extend the captured word to whole chunks and pick the current one.
  always_comb begin
    cap_pad              = '0;
    cap_pad[DATA_W-1:0]  = cap_q;
    chunk                = cap_pad[SIG_W*int'(idx_q) +: SIG_W];
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    count_d  = count_q;
    target_d = target_q;
    cap_d    = cap_q;
    idx_d    = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sig_d    = SEED;
          count_d  = '0;
          target_d = cycles_target;
          state_d  = (cycles_target == 32'd0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (in_valid) begin
          cap_d   = in_data;
          count_d = count_q + 32'd1;
          idx_d   = '0;
          state_d = StFold;
        end
      end
      StFold: begin
        sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ chunk;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = (count_q == target_q) ? StDone : StCollect;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (sig_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sig_q    <= '0;
      count_q  <= '0;
      target_q <= '0;
      cap_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      count_q  <= count_d;
      target_q <= target_d;
      cap_q    <= cap_d;
      idx_q    <= idx_d;
    end
  end

  // Handshake and status outputs decode directly from state.
  always_comb begin
    in_ready   = (state_q == StCollect);
    sig_valid  = (state_q == StDone);
    busy       = (state_q != StIdle);
    sig_out    = sig_q;
    word_count = count_q;
  end

endmodule

// File: tb/tb_out_stream_signature.sv
// Directed self-checking bench for out_stream_signature: one instance with the
// default seed, one with SEED=0 for hand-computable signatures.
module tb_out_stream_signature;

  localparam int unsigned DW = 330;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_a, start_b;
  logic [31:0]   cycles_target;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          sig_ready;

  logic          in_ready_a, sig_valid_a, busy_a;
  logic [31:0]   sig_out_a, word_count_a;
  logic          in_ready_b, sig_valid_b, busy_b;
  logic [31:0]   sig_out_b, word_count_b;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  out_stream_signature u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cycles_target(cycles_target),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .sig_valid(sig_valid_a), .sig_ready(sig_ready), .sig_out(sig_out_a),
    .word_count(word_count_a), .busy(busy_a)
  );

  out_stream_signature #(.SEED(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cycles_target(cycles_target),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .sig_valid(sig_valid_b), .sig_ready(sig_ready), .sig_out(sig_out_b),
    .word_count(word_count_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference MISR fold of one whole word.
  function automatic logic [31:0] fold_word(input logic [31:0] s, input logic [DW-1:0] d);
    logic [351:0] p;
    p = '0;
    p[DW-1:0] = d;
    for (int k = 0; k < 11; k++) begin
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ p[32*k +: 32];
    end
    return s;
  endfunction

  task automatic wait_valid(input bit use_b, input int max, output int n);
    n = 0;
    while (!(use_b ? sig_valid_b : sig_valid_a) && n < max) begin
      tick();
      n++;
    end
    chk("sig_valid_timeout", 64'(use_b ? sig_valid_b : sig_valid_a), 64'(1));
  endtask

  task automatic feed_a(input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!in_ready_a && n < 40) begin
      tick();
      n++;
    end
    chk("feed_ready_a", 64'(in_ready_a), 64'(1));
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_one_b(input logic [DW-1:0] d, input logic [31:0] exp_sig, input string tag);
    int n;
    cycles_target = 32'd1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk({tag, "_ready_collect"}, 64'(in_ready_b), 64'(1));
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_ready_fold"}, 64'(in_ready_b), 64'(0));
    wait_valid(1'b1, 30, n);
    chk({tag, "_latency"}, 64'(n), 64'(11));
    chk({tag, "_sig"}, 64'(sig_out_b), 64'(exp_sig));
    chk({tag, "_count"}, 64'(word_count_b), 64'(1));
  endtask

  initial begin
    logic [DW-1:0] w [4];
    logic [31:0]   gold;
    logic [DW-1:0] one;
    int            acc [$];
    int            cyc;
    int            n;
    bit            stable;

    w[0] = {10'h155, {10{32'hA5A5_5A5A}}};
    w[1] = {10'h2AA, {5{64'h0123_4567_89AB_CDEF}}};
    w[2] = {10'h001, {10{32'h1357_9BDF}}};
    w[3] = {10'h3FF, {10{32'hFFFF_0000}}};
    one  = '0;
    one[0] = 1'b1;

    // Reset held with start and in_valid asserted.
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; in_valid = 1'b1;
    cycles_target = 32'd5; in_data = '1; sig_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready_a), 64'(0));
    chk("rst_sig_valid", 64'(sig_valid_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_sig_out", 64'(sig_out_a), 64'(0));
    chk("rst_word_count", 64'(word_count_a), 64'(0));
    start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy_a), 64'(0));
    chk("post_rst_sig_out", 64'(sig_out_a), 64'(0));

    // Zero target goes straight to DONE with the seed.
    cycles_target = 32'd0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t0_sig_valid", 64'(sig_valid_a), 64'(1));
    chk("t0_sig_out", 64'(sig_out_a), 64'hFFFF_FFFF);
    chk("t0_word_count", 64'(word_count_a), 64'(0));
    chk("t0_in_ready", 64'(in_ready_a), 64'(0));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    chk("t0_idle_valid", 64'(sig_valid_a), 64'(0));
    chk("t0_idle_busy", 64'(busy_a), 64'(0));
    chk("t0_idle_sig_kept", 64'(sig_out_a), 64'hFFFF_FFFF);

    // Single-word signatures with SEED=0.
    run_one_b(one, 32'h0000_0400, "bit0");
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    run_one_b(one << 320, 32'h0000_0001, "bit320");

    // Hold in DONE without sig_ready; a start pulse must not reload.
    stable = 1'b1;
    cycles_target = 32'd7;
    for (int i = 0; i < 5; i++) begin
      start_b = (i == 2);
      tick();
      if (!sig_valid_b || sig_out_b !== 32'h1 || word_count_b !== 32'd1) stable = 1'b0;
    end
    start_b = 1'b0;
    chk("done_hold_stable", 64'(stable), 64'(1));
    chk("done_hold_sig", 64'(sig_out_b), 64'h1);
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    chk("done_release_busy", 64'(busy_b), 64'(0));
    chk("done_release_count", 64'(word_count_b), 64'(1));

    // Back-to-back zero words: accepts spaced 12 cycles apart.
    cycles_target = 32'd3;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    in_data = '0;
    in_valid = 1'b1;
    cyc = 0;
    while (!sig_valid_b && cyc < 60) begin
      if (in_ready_b) acc.push_back(cyc);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc.size()), 64'(3));
    chk("b2b_gap1", 64'(acc.size() > 1 ? acc[1] - acc[0] : -1), 64'(12));
    chk("b2b_gap2", 64'(acc.size() > 2 ? acc[2] - acc[1] : -1), 64'(12));
    chk("b2b_done_cycle", 64'(acc.size() > 2 ? cyc - acc[2] : -1), 64'(12));
    chk("b2b_sig", 64'(sig_out_b), 64'(0));
    chk("b2b_count", 64'(word_count_b), 64'(3));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;

    // Reset during the fold of word 2 of 4.
    cycles_target = 32'd4;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    feed_a(w[0]);
    feed_a(w[1]);
    feed_a(w[2]);
    tick(); tick(); tick();
    chk("midrun_busy", 64'(busy_a), 64'(1));
    chk("midrun_count", 64'(word_count_a), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy_a), 64'(0));
    chk("async_rst_sig", 64'(sig_out_a), 64'(0));
    chk("async_rst_count", 64'(word_count_a), 64'(0));
    chk("async_rst_valid", 64'(sig_valid_a), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh full run against the reference model.
    gold = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) gold = fold_word(gold, w[i]);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) feed_a(w[i]);
    wait_valid(1'b0, 30, n);
    chk("full_sig", 64'(sig_out_a), 64'(gold));
    chk("full_count", 64'(word_count_a), 64'(4));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    chk("full_idle", 64'(busy_a), 64'(0));

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
